// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle CPU control FSM with memory-wait timeout and sticky trap
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101) into the branch state.
module mc_ctrl #(
    parameter int TMO_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic       pc_wr,
    output logic       iord,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic       func_sel,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MADR = 4'd2,
        S_MRD  = 4'd3,
        S_MWB  = 4'd4,
        S_MWR  = 4'd5,
        S_REX  = 4'd6,
        S_RWB  = 4'd7,
        S_IEX  = 4'd8,
        S_IWB  = 4'd9,
        S_BR   = 4'd10,
        S_JMP  = 4'd11,
        S_TRAP = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001110;

    // Last count value before the timeout: a wait cycle seen with the counter
    // here is the (2^TMO_W-1)-th consecutive one.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [TMO_W-1:0] CNT_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;

    // Raw Moore decodes; strobes are masked by rst before leaving the block.
    logic mem_rd_dec, mem_wr_dec, ir_wr_dec, reg_wr_dec, pc_wr_dec;
    logic br_take;

    // State and wait-counter registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter only survives while a wait state loops on
    // itself, so every entry into IF/MRD/MWR starts from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            S_IF: begin
                if (mem_ready)              state_d = S_ID;
                else if (cnt_q == TMO_LAST) state_d = S_TRAP;
                else                        cnt_d   = cnt_q + CNT_ONE;
            end
            S_ID: begin
                case (opcode)
                    OP_RTYPE:                 state_d = S_REX;
                    OP_LW, OP_SW:             state_d = S_MADR;
                    OP_BEQ:                   state_d = S_BR;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:                   state_d = S_BR;
`endif
                    OP_J:                     state_d = S_JMP;
                    OP_ADDI, OP_ANDI, OP_ORI,
                    OP_SLTI, OP_XORI:         state_d = S_IEX;
                    default:                  state_d = S_TRAP;
                endcase
            end
            S_MADR: begin
                if (opcode == OP_LW)      state_d = S_MRD;
                else if (opcode == OP_SW) state_d = S_MWR;
                else                      state_d = S_TRAP;
            end
            S_MRD: begin
                if (mem_ready)              state_d = S_MWB;
                else if (cnt_q == TMO_LAST) state_d = S_TRAP;
                else                        cnt_d   = cnt_q + CNT_ONE;
            end
            S_MWB:  state_d = S_IF;
            S_MWR: begin
                if (mem_ready)              state_d = S_IF;
                else if (cnt_q == TMO_LAST) state_d = S_TRAP;
                else                        cnt_d   = cnt_q + CNT_ONE;
            end
            S_REX:  state_d = S_RWB;
            S_RWB:  state_d = S_IF;
            S_IEX:  state_d = S_IWB;
            S_IWB:  state_d = S_IF;
            S_BR:   state_d = S_IF;
            S_JMP:  state_d = S_IF;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Branch condition: beq takes on zero, bne (when enabled) on not-zero.
    always_comb begin
        br_take = zero;
`ifdef MC_CTRL_BNE_EN
        if (opcode == OP_BNE) br_take = ~zero;
`endif
    end

    // Per-state output decode; everything not named for a state stays 0.
    always_comb begin
        mem_rd_dec = 1'b0;
        mem_wr_dec = 1'b0;
        ir_wr_dec  = 1'b0;
        reg_wr_dec = 1'b0;
        pc_wr_dec  = 1'b0;
        iord       = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        alu_src_a  = 1'b0;
        func_sel   = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        trap       = 1'b0;
        case (state_q)
            S_IF: begin
                mem_rd_dec = 1'b1;
                alu_src_b  = 2'b01;
                alu_op     = 2'b11;
                ir_wr_dec  = mem_ready;
                pc_wr_dec  = mem_ready;
            end
            S_ID: begin
                alu_src_b = 2'b11;
                alu_op    = 2'b11;
            end
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = 2'b11;
            end
            S_MRD: begin
                mem_rd_dec = 1'b1;
                iord       = 1'b1;
            end
            S_MWB: begin
                reg_wr_dec = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MWR: begin
                mem_wr_dec = 1'b1;
                iord       = 1'b1;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
            end
            S_RWB: begin
                reg_wr_dec = 1'b1;
                reg_dst    = 1'b1;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                func_sel  = 1'b1;
            end
            S_IWB: begin
                reg_wr_dec = 1'b1;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                pc_src    = 2'b01;
                pc_wr_dec = br_take;
            end
            S_JMP: begin
                pc_wr_dec = 1'b1;
                pc_src    = 2'b10;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                trap = 1'b0;
            end
        endcase
    end

    // Strobes are held low for as long as rst is asserted, even though the
    // register already reads IF.
    assign mem_rd = mem_rd_dec & ~rst;
    assign mem_wr = mem_wr_dec & ~rst;
    assign ir_wr  = ir_wr_dec  & ~rst;
    assign reg_wr = reg_wr_dec & ~rst;
    assign pc_wr  = pc_wr_dec  & ~rst;
    assign state  = state_q;

endmodule
